// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: sequences fetch, decode, execute,
// memory and write-back, with a stall timeout and sticky trap.
module multicycle_controller #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     ins,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_ctrl,
  output logic [2:0]           imm_src,
  output logic [1:0]           result_src,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam int WW = (WAIT_MAX < 3) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WW-1:0] W_LIM = WW'(WAIT_MAX - 1);

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE,
    S_MEMWB, S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t               r_state;
  logic [WW-1:0]        r_wait;
  logic [CNT_WIDTH-1:0] r_instret;
  logic                 r_trap;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_unused;
  logic       w_is_load, w_is_store, w_is_r, w_is_i;
  logic       w_is_lui, w_is_auipc, w_is_br;
  logic       w_is_jal, w_is_jalr;
  logic       w_is_mem, w_is_alu, w_is_jmp;
  logic       w_stall, w_timeout;
  logic       w_br_take, w_br_bad;
  logic [3:0] w_exec_ctrl;

  assign w_op     = ins[6:0];
  assign w_f3     = ins[14:12];
  assign w_f7b5   = ins[30];
  assign w_unused = ^ins;

  assign w_is_load  = (w_op == OP_LOAD);
  assign w_is_store = (w_op == OP_STORE);
  assign w_is_r     = (w_op == OP_R);
  assign w_is_i     = (w_op == OP_I);
  assign w_is_lui   = (w_op == OP_LUI);
  assign w_is_auipc = (w_op == OP_AUIPC);
  assign w_is_br    = (w_op == OP_BR);
  assign w_is_jal   = (w_op == OP_JAL);
  assign w_is_jalr  = (w_op == OP_JALR);

  assign w_is_mem = w_is_load | w_is_store;
  assign w_is_alu = w_is_r | w_is_i | w_is_lui | w_is_auipc;
  assign w_is_jmp = w_is_jal | w_is_jalr;

  // A stall is any memory-waiting state without completion this cycle.
  assign w_stall = (r_state == S_FETCH || r_state == S_MEMREAD ||
                    r_state == S_MEMWRITE) && !mem_ready;
  assign w_timeout = w_stall && (r_wait == W_LIM);

  // EXEC ALU op: funct7[5] only matters for sub/sra (R) and srai (I).
  always_comb begin
    w_exec_ctrl = ALU_ADD;
    if (w_is_r || w_is_i) begin
      case (w_f3)
        3'd0:    w_exec_ctrl = (w_is_r && w_f7b5) ? ALU_SUB : ALU_ADD;
        3'd1:    w_exec_ctrl = ALU_SLL;
        3'd2:    w_exec_ctrl = ALU_SLT;
        3'd3:    w_exec_ctrl = ALU_SLTU;
        3'd4:    w_exec_ctrl = ALU_XOR;
        3'd5:    w_exec_ctrl = w_f7b5 ? ALU_SRA : ALU_SRL;
        3'd6:    w_exec_ctrl = ALU_OR;
        default: w_exec_ctrl = ALU_AND;
      endcase
    end
  end

  // Branch condition from funct3; funct3 2/3 are not branches.
  always_comb begin
    w_br_take = 1'b0;
    w_br_bad  = 1'b0;
    case (w_f3)
      3'd0:    w_br_take = zero;
      3'd1:    w_br_take = ~zero;
      3'd4:    w_br_take = lt;
      3'd5:    w_br_take = ~lt;
      3'd6:    w_br_take = ltu;
      3'd7:    w_br_take = ~ltu;
      default: w_br_bad  = 1'b1;
    endcase
  end

  // Sequencer: state, stall counter, retire counter and sticky trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_instret <= '0;
      r_trap    <= 1'b0;
    end else begin
      r_wait <= (w_stall && !w_timeout) ? r_wait + WW'(1) : '0;
      case (r_state)
        S_FETCH: begin
          if (w_timeout) begin
            r_state <= S_HALT;
            r_trap  <= 1'b1;
          end else if (mem_ready) begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            w_is_mem: r_state <= S_MEMADR;
            w_is_alu: r_state <= S_EXEC;
            w_is_br:  r_state <= S_BRANCH;
            w_is_jmp: r_state <= S_JUMP;
            default: begin
              r_state <= S_HALT;
              r_trap  <= 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          r_state <= w_is_store ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          if (w_timeout) begin
            r_state <= S_HALT;
            r_trap  <= 1'b1;
          end else if (mem_ready) begin
            r_state <= S_MEMWB;
          end
        end
        S_MEMWRITE: begin
          if (w_timeout) begin
            r_state <= S_HALT;
            r_trap  <= 1'b1;
          end else if (mem_ready) begin
            r_state   <= S_FETCH;
            r_instret <= r_instret + CNT_WIDTH'(1);
          end
        end
        S_MEMWB, S_ALUWB, S_JUMP: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + CNT_WIDTH'(1);
        end
        S_EXEC: begin
          r_state <= S_ALUWB;
        end
        S_BRANCH: begin
          if (w_br_bad) begin
            r_state <= S_HALT;
            r_trap  <= 1'b1;
          end else begin
            r_state   <= S_FETCH;
            r_instret <= r_instret + CNT_WIDTH'(1);
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
          r_trap  <= 1'b1;
        end
        default: begin
          r_state <= S_HALT;
          r_trap  <= 1'b1;
        end
      endcase
    end
  end

  assign trap    = r_trap;
  assign instret = r_instret;

  // Datapath controls from state, instruction and flags; all 0 in reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_ctrl   = ALU_ADD;
    imm_src    = 3'd0;
    result_src = 2'd0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'd2;
          end
        end
        S_MEMADR: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          imm_src   = w_is_store ? 3'd1 : 3'd0;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = 2'd1;
        end
        S_EXEC: begin
          alu_ctrl = w_exec_ctrl;
          unique case (1'b1)
            w_is_lui: begin
              alu_src_a = 2'd2;
              alu_src_b = 2'd1;
              imm_src   = 3'd3;
            end
            w_is_auipc: begin
              alu_src_a = 2'd0;
              alu_src_b = 2'd1;
              imm_src   = 3'd3;
            end
            w_is_i: begin
              alu_src_a = 2'd1;
              alu_src_b = 2'd1;
            end
            default: begin
              alu_src_a = 2'd1;
            end
          endcase
        end
        S_ALUWB: begin
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'd1;
          alu_ctrl  = ALU_SUB;
          imm_src   = 3'd2;
          pc_write  = w_br_take & ~w_br_bad;
        end
        S_JUMP: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          result_src = 2'd2;
          alu_src_b  = 2'd1;
          if (w_is_jalr) begin
            alu_src_a = 2'd1;
          end else begin
            imm_src = 3'd4;
          end
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule
